// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, default parameters and width helpers for the FIFO write-port arbiter.
`timescale 1ns/1ps
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF      = 4;
  localparam int DSIZE_DEF     = 8;
  localparam int BURST_LEN_DEF = 4;

  localparam int IDW  = $clog2(NREQ_DEF);
  localparam int CNTW = $clog2(BURST_LEN_DEF + 1);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int b);
    return (b > 0) ? $clog2(b + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, modulo NREQ.
`timescale 1ns/1ps
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  output logic [PW-1:0]   o_pick,
  output logic            o_any
);

  logic [PW:0] w_idx;

  // Scan from the farthest offset down so the closest hit is the last one assigned.
  always_comb begin
    o_pick = '0;
    o_any  = 1'b0;
    w_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_rr_ptr} + (PW + 1)'(k);
      if (w_idx >= (PW + 1)'(NREQ)) begin
        w_idx = w_idx - (PW + 1)'(NREQ);
      end
      if (i_req[w_idx[PW-1:0]]) begin
        o_pick = w_idx[PW-1:0];
        o_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async FIFO write port among NREQ requesters.
// Optional word/stall statistics counters are built when FIFO_WR_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ      = NREQ_DEF,
  parameter  int DSIZE     = DSIZE_DEF,
  parameter  int BURST_LEN = BURST_LEN_DEF,
  localparam int OWW       = (NREQ == NREQ_DEF) ? IDW : idx_w(NREQ),
  localparam int CW        = (BURST_LEN == BURST_LEN_DEF) ? CNTW : cnt_w(BURST_LEN)
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DSIZE-1:0]  wdata_in,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  output logic [OWW-1:0]         owner,
  output logic                   winc,
  output logic [DSIZE-1:0]       wdata,
  input  logic                   wfull
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [31:0]            beat_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  arb_state_t       r_state;
  logic             r_busy;
  logic [OWW-1:0]   r_owner;
  logic [OWW-1:0]   r_rr_ptr;
  logic [CW-1:0]    r_cnt;

  logic [OWW-1:0]   w_pick;
  logic             w_any;
  logic             w_req_own;
  logic             w_winc;
  logic             w_last;
  logic             w_release;
  logic [OWW-1:0]   w_owner_next;
  logic [DSIZE-1:0] w_wdata;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (OWW)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_pick   (w_pick),
    .o_any    (w_any)
  );

  assign w_req_own = req[r_owner];
  assign w_winc    = r_busy & w_req_own & ~wfull;
  assign w_last    = (r_cnt == CW'(BURST_LEN - 1));
  assign w_release = ~w_req_own | (w_winc & w_last);

  // Explicit wrap compare keeps non-power-of-2 NREQ correct.
  assign w_owner_next = (r_owner == OWW'(NREQ - 1)) ? '0 : r_owner + OWW'(1);

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == OWW'(i)) begin
        w_wdata = wdata_in[i*DSIZE +: DSIZE];
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_cnt   <= '0;
            r_state <= BURST;
            r_busy  <= 1'b1;
          end
        end
        BURST: begin
          if (w_winc) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (w_release) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_owner_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign winc  = w_winc;
  assign wdata = w_wdata;
  assign ack   = w_winc ? (NREQ'(1) << r_owner) : '0;
  assign busy  = r_busy;
  assign owner = r_owner;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] r_beat_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  // A stall is a cycle where the owner has data but the FIFO refuses it.
  assign w_stall = r_busy & w_req_own & wfull;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_winc) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign beat_cnt  = r_beat_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
